instruction_sequencer: RTL and testbench
========================================

// Module: instruction_sequencer
// PURPOSE
//  Fetch/dispatch controller for the instruction memory (bus select 1). Walks the PC from 0 and
//  issues reads on the shared address bus. Captures each 32-bit word {op,dest,src1,src2}, decodes
//  the opcode and starts the Matrix ALU (select 2) or Integer ALU (select 3). Waits for the ALU's
//  done, then advances; halts on STOP (FFh), an illegal opcode or end of memory.
// PARAMETERS
//  MEM_DEPTH     10     number of instruction words; PC range 0..MEM_DEPTH-1
//  INSTR_SELECT  4'h1   address[15:12] value for instruction memory
//  WDOG_CYCLES   255    EXEC cycles before watchdog fault (used only with SEQ_WATCHDOG_EN)
// PORTS
//  Clk        in   1    clock, all state on posedge
//  nReset     in   1    asynchronous active-low reset
//  Start      in   1    1-cycle pulse; starts from IDLE or restarts from HALT at PC 0
//  Address    out  16   {INSTR_SELECT, 12'(PC)} during fetch, else 16'h0000
//  nRead      out  1    0 while fetching (FETCH and WAIT states), else 1
//  DataIn     in   256  instruction memory read data; only [31:0] used
//  Dest       out  8    operand fields of current instruction, held stable from DISPATCH to EXEC exit
//  Src1       out  8    (see Dest)
//  Src2       out  8    (see Dest)
//  Opcode     out  8    current opcode, held as for Dest
//  MatrixGo   out  1    1-cycle start pulse, opcodes 00h-05h
//  IntGo      out  1    1-cycle start pulse, opcodes 10h-13h
//  MatrixDone in   1    level/pulse from Matrix ALU; sampled only in EXEC
//  IntDone    in   1    level/pulse from Integer ALU; sampled only in EXEC
//  Busy       out  1    1 in every state except IDLE and HALT
//  Halted     out  1    1 in HALT
//  Fault      out  1    1 in HALT if entered by illegal opcode, end of memory or watchdog
//  Pc         out  12   current PC
// BEHAVIOUR
//  Reset: state IDLE, Pc=0, Address=0, nRead=1, Opcode/Dest/Src1/Src2=0, Go pulses=0,
//         Busy=Halted=Fault=0.
//   - Reset asserted mid-operation aborts immediately; no pending Go or read is completed.
//  IDLE     -> FETCH on Start.
//  FETCH    drive Address/nRead=0 for one cycle -> WAIT (the memory registers data on this edge).
//  WAIT     nRead still 0; capture DataIn[31:0] into the instruction register -> DECODE.
//  DECODE   STOP (FFh) -> HALT, Fault=0.
//           Matrix op -> DISPATCH.
//           Int op -> DISPATCH.
//           any other opcode -> HALT, Fault=1.
//  DISPATCH pulse the matching Go for exactly one cycle -> EXEC.
//  EXEC     wait for the matching Done; the non-matching Done is ignored.
//           On Done with Pc==MEM_DEPTH-1 -> HALT, Fault=1 (ran off end without STOP).
//           Otherwise Pc<=Pc+1 -> FETCH.
//  HALT     sticky. Start -> Pc=0, Fault=0 -> FETCH.
//  Start outside IDLE/HALT is ignored.
//  Done in the same cycle Go pulses (DISPATCH) is ignored; only EXEC samples it.
//  Fetch-to-Go latency 3 cycles (FETCH, WAIT, DECODE); Go asserted in the 4th cycle after entering FETCH.
//  Pc never exceeds MEM_DEPTH-1; the 12-bit increment never wraps.
// CONFIGURATION
//  SEQ_WATCHDOG_EN defined:
//   - 8-bit-min counter clears on EXEC entry and counts each EXEC cycle.
//   - Reaching WDOG_CYCLES without the matching Done -> HALT, Fault=1.
//  SEQ_WATCHDOG_EN undefined: no counter is built; EXEC waits indefinitely.
// STRUCTURE
//  Package seq_pkg:
//   - state_t enum {IDLE,FETCH,WAIT,DECODE,DISPATCH,EXEC,HALT}.
//   - Opcode constants OP_MMULT..OP_MSCALEIMM (00h-05h), OP_IADD..OP_IDIV (10h-13h), OP_STOP=FFh.
//   - Bus select constants SEL_MAIN=0, SEL_INSTR=1, SEL_MALU=2, SEL_IALU=3, SEL_REG=4, SEL_EXEC=5.
//  Sub-module seq_opcode_decode: combinational opcode -> {is_matrix, is_int, is_stop, illegal}.
// TESTING
//  1. Mem {01_02_00_01, FF_00_00_00}, Start -> MatrixGo once with Dest=02,Src1=00,Src2=01;
//     after MatrixDone -> HALT, Fault=0, Pc=1.
//  2. Word 11_0A_01_81 -> IntGo single pulse, MatrixGo stays 0.
//     MatrixDone in EXEC is ignored; IntDone advances Pc.
//  3. Word 07_00_00_00 at Pc=0 -> HALT in DECODE, Fault=1, no Go pulse.
//  4. Ten non-STOP ops, MEM_DEPTH=10 -> Pc counts 0..9.
//     After the 10th Done -> HALT, Fault=1, Address never selects word 10.
//  5. nReset asserted during EXEC -> all outputs at reset values the same cycle.
//     Start afterwards refetches Pc=0.
//  6. SEQ_WATCHDOG_EN, WDOG_CYCLES=8, Done withheld -> HALT, Fault=1 after 8 EXEC cycles.
//     Without the macro, the design stays in EXEC for 1000 cycles.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared states, opcodes and bus selects for the instruction sequencer
package seq_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, DECODE, DISPATCH, EXEC, HALT} state_t;
  localparam logic [7:0] OP_MMULT     = 8'h00;
  localparam logic [7:0] OP_MADD      = 8'h01;
  localparam logic [7:0] OP_MSUB      = 8'h02;
  localparam logic [7:0] OP_MTRANS    = 8'h03;
  localparam logic [7:0] OP_MSCALE    = 8'h04;
  localparam logic [7:0] OP_MSCALEIMM = 8'h05;
  localparam logic [7:0] OP_IADD      = 8'h10;
  localparam logic [7:0] OP_ISUB      = 8'h11;
  localparam logic [7:0] OP_IMUL      = 8'h12;
  localparam logic [7:0] OP_IDIV      = 8'h13;
  localparam logic [7:0] OP_STOP      = 8'hFF;
  localparam logic [3:0] SEL_MAIN  = 4'h0;
  localparam logic [3:0] SEL_INSTR = 4'h1;
  localparam logic [3:0] SEL_MALU  = 4'h2;
  localparam logic [3:0] SEL_IALU  = 4'h3;
  localparam logic [3:0] SEL_REG   = 4'h4;
  localparam logic [3:0] SEL_EXEC  = 4'h5;
endpackage

// File: rtl/seq_opcode_decode.sv
// seq_opcode_decode: classifies an opcode as matrix, integer, stop or illegal
module seq_opcode_decode
  import seq_pkg::*;
(
  input  logic [7:0] opcode,
  output logic       is_matrix,
  output logic       is_int,
  output logic       is_stop,
  output logic       illegal
);
  // pure range checks on the opcode byte
  always_comb begin
    is_matrix = opcode <= OP_MSCALEIMM;
    is_int    = opcode >= OP_IADD && opcode <= OP_IDIV;
    is_stop   = opcode == OP_STOP;
    illegal   = !(is_matrix || is_int || is_stop);
  end
endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetches instruction words and dispatches them to the matrix/integer ALUs
// Optional EXEC watchdog enabled by defining SEQ_WATCHDOG_EN.
module instruction_sequencer
  import seq_pkg::*;
#(
  parameter int         MEM_DEPTH    = 10,
  parameter logic [3:0] INSTR_SELECT = SEL_INSTR,
  parameter int         WDOG_CYCLES  = 255
) (
  input  logic         Clk,
  input  logic         nReset,
  input  logic         Start,
  output logic [15:0]  Address,
  output logic         nRead,
  input  logic [255:0] DataIn,
  output logic [7:0]   Dest,
  output logic [7:0]   Src1,
  output logic [7:0]   Src2,
  output logic [7:0]   Opcode,
  output logic         MatrixGo,
  output logic         IntGo,
  input  logic         MatrixDone,
  input  logic         IntDone,
  output logic         Busy,
  output logic         Halted,
  output logic         Fault,
  output logic [11:0]  Pc
);
  state_t state, state_next;
  logic [11:0] pc;
  logic [31:0] ir;
  logic fault, is_matrix, is_int, is_stop, illegal, done, last, wdog_hit, unused_data;
  assign unused_data = ^{DataIn[255:32], illegal};
  seq_opcode_decode u_decode (
    .opcode(ir[31:24]), .is_matrix(is_matrix), .is_int(is_int), .is_stop(is_stop), .illegal(illegal)
  );
  assign done = is_matrix ? MatrixDone : IntDone;
  assign last = pc == 12'(MEM_DEPTH - 1);
`ifdef SEQ_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1) > 8 ? $clog2(WDOG_CYCLES + 1) : 8;
  logic [WW-1:0] wdog;
  // counts EXEC cycles, cleared on the way into EXEC
  always_ff @(posedge Clk or negedge nReset)
    if (!nReset) wdog <= '0;
    else if (state == DISPATCH) wdog <= '0;
    else if (state == EXEC) wdog <= wdog + 1'b1;
  assign wdog_hit = wdog == WW'(WDOG_CYCLES - 1);
`else
  localparam int unused_wdog = WDOG_CYCLES;
  assign wdog_hit = 1'b0;
`endif
  // state register
  always_ff @(posedge Clk or negedge nReset)
    if (!nReset) state <= IDLE;
    else state <= state_next;
  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     state_next = Start ? FETCH : IDLE;
      FETCH:    state_next = WAIT;
      WAIT:     state_next = DECODE;
      DECODE:   state_next = (is_matrix || is_int) ? DISPATCH : HALT;
      DISPATCH: state_next = EXEC;
      EXEC:     state_next = done ? (last ? HALT : FETCH) : (wdog_hit ? HALT : EXEC);
      HALT:     state_next = Start ? FETCH : HALT;
      default:  state_next = IDLE;
    endcase
  end
  // PC, instruction register and fault flag; fault is decided on HALT entry
  always_ff @(posedge Clk or negedge nReset)
    if (!nReset) begin
      pc    <= '0;
      ir    <= '0;
      fault <= 1'b0;
    end else begin
      if (state == WAIT) ir <= DataIn[31:0];
      if (state == EXEC && done && !last) pc <= pc + 1'b1;
      if (state == HALT && Start) begin
        pc    <= '0;
        fault <= 1'b0;
      end
      if (state != HALT && state_next == HALT) fault <= !(state == DECODE && is_stop);
    end
  // outputs decoded from state and held registers
  always_comb begin
    Address  = (state == FETCH || state == WAIT) ? {INSTR_SELECT, pc} : 16'h0000;
    nRead    = !(state == FETCH || state == WAIT);
    MatrixGo = state == DISPATCH && is_matrix;
    IntGo    = state == DISPATCH && is_int;
    Busy     = state != IDLE && state != HALT;
    Halted   = state == HALT;
    Fault    = fault;
    Pc       = pc;
    Opcode   = ir[31:24];
    Dest     = ir[23:16];
    Src1     = ir[15:8];
    Src2     = ir[7:0];
  end
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: directed self-checking bench for instruction_sequencer
module tb_instruction_sequencer;
  logic Clk = 0, nReset = 0, Start = 0, MatrixDone = 0, IntDone = 0;
  logic [255:0] DataIn = '0;
  logic [15:0] Address;
  logic nRead, MatrixGo, IntGo, Busy, Halted, Fault;
  logic [7:0] Dest, Src1, Src2, Opcode;
  logic [11:0] Pc;
  logic [31:0] mem [0:15];
  int n_cmp = 0, n_err = 0, mgo = 0, igo = 0, m0, i0;
  bit saw_oob = 0;

  instruction_sequencer #(.MEM_DEPTH(10), .INSTR_SELECT(4'h1), .WDOG_CYCLES(8)) dut (
    .Clk(Clk), .nReset(nReset), .Start(Start), .Address(Address), .nRead(nRead), .DataIn(DataIn),
    .Dest(Dest), .Src1(Src1), .Src2(Src2), .Opcode(Opcode), .MatrixGo(MatrixGo), .IntGo(IntGo),
    .MatrixDone(MatrixDone), .IntDone(IntDone), .Busy(Busy), .Halted(Halted), .Fault(Fault), .Pc(Pc)
  );

  always #5 Clk = ~Clk;

  // registered instruction memory model
  always @(posedge Clk) if (!nRead && Address[15:12] == 4'h1) DataIn <= {224'b0, mem[Address[3:0]]};

  // pulse and out-of-range fetch monitor
  always @(negedge Clk) begin
    if (MatrixGo) mgo++;
    if (IntGo) igo++;
    if (!nRead && Address[11:0] >= 12'd10) saw_oob = 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic pulse_start();
    Start = 1;
    step(1);
    Start = 0;
  endtask

  task automatic wait_go();
    int k = 0;
    while (!(MatrixGo || IntGo) && k < 20) begin step(1); k++; end
    chk("go_seen", {31'b0, MatrixGo | IntGo}, 1);
  endtask

  task automatic wait_halt();
    int k = 0;
    while (!Halted && k < 20) begin step(1); k++; end
    chk("halt_seen", {31'b0, Halted}, 1);
  endtask

  task automatic run_op(input bit mat, input int exp_pc);
    wait_go();
    chk("op_pc", {20'b0, Pc}, exp_pc);
    chk("op_mgo", {31'b0, MatrixGo}, {31'b0, mat});
    chk("op_igo", {31'b0, IntGo}, {31'b0, !mat});
    step(1);
    if (mat) MatrixDone = 1; else IntDone = 1;
    step(1);
    MatrixDone = 0;
    IntDone = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hFF00_0000;
    // reset values
    step(2);
    chk("rst_addr", {16'b0, Address}, 0);
    chk("rst_nread", {31'b0, nRead}, 1);
    chk("rst_busy", {31'b0, Busy}, 0);
    chk("rst_halt", {31'b0, Halted}, 0);
    chk("rst_fault", {31'b0, Fault}, 0);
    chk("rst_pc", {20'b0, Pc}, 0);
    chk("rst_ops", {Opcode, Dest, Src1, Src2}, 0);
    nReset = 1;
    step(1);
    // 1: matrix op then STOP
    mem[0] = 32'h0102_0001;
    pulse_start();
    chk("t1_fetch_addr", {16'b0, Address}, 32'h1000);
    chk("t1_fetch_nread", {31'b0, nRead}, 0);
    chk("t1_busy", {31'b0, Busy}, 1);
    step(1);
    chk("t1_wait_nread", {31'b0, nRead}, 0);
    step(2);
    chk("t1_mgo", {31'b0, MatrixGo}, 1);
    chk("t1_fields", {Opcode, Dest, Src1, Src2}, 32'h0102_0001);
    step(1);
    chk("t1_mgo_off", {31'b0, MatrixGo}, 0);
    MatrixDone = 1;
    step(1);
    MatrixDone = 0;
    wait_halt();
    chk("t1_fault", {31'b0, Fault}, 0);
    chk("t1_pc", {20'b0, Pc}, 1);
    chk("t1_go_counts", {mgo[15:0], igo[15:0]}, 32'h0001_0000);
    // 2: integer op, wrong done ignored
    mem[0] = 32'h110A_0181;
    m0 = mgo; i0 = igo;
    pulse_start();
    chk("t2_restart_pc", {20'b0, Pc}, 0);
    step(3);
    chk("t2_igo", {31'b0, IntGo}, 1);
    chk("t2_mgo", {31'b0, MatrixGo}, 0);
    chk("t2_fields", {Opcode, Dest, Src1, Src2}, 32'h110A_0181);
    IntDone = 1;
    step(1);
    IntDone = 0;
    chk("t2_dispatch_done_ignored", {19'b0, Busy, Pc}, {19'b0, 1'b1, 12'd0});
    chk("t2_igo_off", {31'b0, IntGo}, 0);
    MatrixDone = 1;
    step(3);
    MatrixDone = 0;
    chk("t2_mdone_ignored", {19'b0, nRead, Pc}, {19'b0, 1'b1, 12'd0});
    IntDone = 1;
    step(1);
    IntDone = 0;
    chk("t2_advance", {19'b0, nRead, Pc}, {19'b0, 1'b0, 12'd1});
    wait_halt();
    chk("t2_fault", {31'b0, Fault}, 0);
    chk("t2_go_delta", {mgo - m0}, 0);
    chk("t2_igo_delta", {igo - i0}, 1);
    // 3: illegal opcode
    mem[0] = 32'h0700_0000;
    m0 = mgo; i0 = igo;
    pulse_start();
    step(3);
    chk("t3_halt", {31'b0, Halted}, 1);
    chk("t3_fault", {31'b0, Fault}, 1);
    chk("t3_pc", {20'b0, Pc}, 0);
    chk("t3_no_go", mgo + igo - m0 - i0, 0);
    // 4: run off the end of memory
    for (int i = 0; i < 10; i++) begin
      logic [7:0] op;
      op = (i % 2 == 1) ? 8'h10 + 8'(i % 4) : 8'(i % 6);
      mem[i] = {op, 8'(i), 16'h0000};
    end
    pulse_start();
    chk("t4_fault_cleared", {31'b0, Fault}, 0);
    for (int i = 0; i < 10; i++) run_op(i % 2 == 0, i);
    wait_halt();
    chk("t4_fault", {31'b0, Fault}, 1);
    chk("t4_pc", {20'b0, Pc}, 9);
    chk("t4_no_oob", {31'b0, saw_oob}, 0);
    // 5: async reset during EXEC
    pulse_start();
    run_op(1, 0);
    run_op(0, 1);
    wait_go();
    step(1);
    chk("t5_pre_pc", {20'b0, Pc}, 2);
    #2 nReset = 0;
    #1;
    chk("t5_busy", {31'b0, Busy}, 0);
    chk("t5_pc", {20'b0, Pc}, 0);
    chk("t5_bus", {15'b0, nRead, Address}, 32'h0001_0000);
    chk("t5_ops", {Opcode, Dest, Src1, Src2}, 0);
    chk("t5_flags", {28'b0, MatrixGo, IntGo, Halted, Fault}, 0);
    step(1);
    nReset = 1;
    step(1);
    pulse_start();
    chk("t5_refetch", {4'b0, Pc, Address}, 32'h0000_1000);
    // 6: Done withheld in EXEC
    step(3);
    chk("t6_mgo", {31'b0, MatrixGo}, 1);
`ifdef SEQ_WATCHDOG_EN
    step(8);
    chk("t6_exec8", {30'b0, Busy, Halted}, 32'h2);
    step(1);
    chk("t6_wdog_halt", {30'b0, Halted, Fault}, 32'h3);
`else
    step(1000);
    chk("t6_stuck", {30'b0, Busy, Halted}, 32'h2);
    chk("t6_pc", {20'b0, Pc}, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
